// File: rtl/id_issue_pkg.sv
// Shared defaults and entry layout for the decode-to-execute issue queue.
// Widths here match the default DATA_W/REG_AW of id_issue_queue.
package id_issue_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_AW_DEF = 4;
  localparam int DEPTH_DEF  = 2;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] payload;
    logic [REG_AW_DEF-1:0] src1;
    logic [REG_AW_DEF-1:0] src2;
    logic                  two_src;
    logic                  ign;
    logic                  wb_en;
    logic [REG_AW_DEF-1:0] dest;
  } entry_t;

endpackage

// File: rtl/id_hazard_check.sv
// Head-entry RAW hazard comparator against EXE/MEM destinations.
// FWD_EN=1: only an EXE-stage load stalls; otherwise any EXE/MEM writer.
module id_hazard_check #(
  parameter int REG_AW = 4,
  parameter int FWD_EN = 0
) (
  input  logic [REG_AW-1:0] src1_i,
  input  logic [REG_AW-1:0] src2_i,
  input  logic              two_src_i,
  input  logic              ign_i,
  input  logic              exe_wb_en_i,
  input  logic              exe_mem_r_en_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  input  logic              mem_wb_en_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  output logic              hazard_o
);

  logic exe_hit;
  logic mem_hit;
  logic fwd_hz;
  logic nofwd_hz;

  always_comb begin
    exe_hit  = (src1_i == exe_dest_i) ||
               (two_src_i && (src2_i == exe_dest_i));
    mem_hit  = (src1_i == mem_dest_i) ||
               (two_src_i && (src2_i == mem_dest_i));
    fwd_hz   = exe_wb_en_i && exe_mem_r_en_i && exe_hit;
    nofwd_hz = (exe_wb_en_i && exe_hit) ||
               (mem_wb_en_i && mem_hit);
    hazard_o = !ign_i && ((FWD_EN != 0) ? fwd_hz : nofwd_hz);
  end

endmodule

// File: rtl/id_issue_queue.sv
// Circular issue buffer between decode and execute with head hazard check.
// Ports: in_* decode side, out_* execute side, exe_/mem_* hazard sources.
module id_issue_queue
  import id_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int FWD_EN = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   freeze,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_payload,
  input  logic [REG_AW-1:0]      in_src1,
  input  logic [REG_AW-1:0]      in_src2,
  input  logic                   in_two_src,
  input  logic                   in_ignore_hazard,
  input  logic                   in_wb_en,
  input  logic [REG_AW-1:0]      in_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [REG_AW-1:0]      exe_dest,
  input  logic                   mem_wb_en,
  input  logic [REG_AW-1:0]      mem_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_payload,
  output logic                   out_wb_en,
  output logic [REG_AW-1:0]      out_dest,
  output logic                   hazard_stall,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              two_src;
    logic              ign;
    logic              wb_en;
    logic [REG_AW-1:0] dest;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          wr_ent;
  ent_t          head;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq;
  logic          deq;
  logic          hazard;
  logic          nonempty;

  assign head     = mem_q[rp_q];
  assign nonempty = (cnt_q != '0);

  always_comb begin
    wr_ent         = '0;
    wr_ent.payload = in_payload;
    wr_ent.src1    = in_src1;
    wr_ent.src2    = in_src2;
    wr_ent.two_src = in_two_src;
    wr_ent.ign     = in_ignore_hazard;
    wr_ent.wb_en   = in_wb_en;
    wr_ent.dest    = in_dest;
  end

  id_hazard_check #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_hz (
    .src1_i         (head.src1),
    .src2_i         (head.src2),
    .two_src_i      (head.two_src),
    .ign_i          (head.ign),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_r_en_i (exe_mem_r_en),
    .exe_dest_i     (exe_dest),
    .mem_wb_en_i    (mem_wb_en),
    .mem_dest_i     (mem_dest),
    .hazard_o       (hazard)
  );

  // in_ready looks only at state and side controls, never at out_ready.
  assign in_ready = (cnt_q < CW'(DEPTH)) && !freeze && !flush;
  assign out_valid = nonempty && !hazard && !freeze && !flush;
  assign hazard_stall = nonempty && hazard;

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  assign out_payload = head.payload;
  assign out_wb_en   = head.wb_en;
  assign out_dest    = head.dest;
  assign count       = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wp_d = wp_q + PW'(1);
      if (deq) rp_d = rp_q + PW'(1);
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq) begin
      mem_q[wp_q] <= wr_ent;
    end
  end

endmodule
